// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
//   Shared definitions for the round-robin mux arbiter slice:
//   - default parameter values
//   - arbiter state encoding (IDLE / GRANT)
//   - onehot_to_idx(): encodes a one-hot vector (up to 16 bits) to its index
package mux_arb_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_SEL_W    = 2;
  localparam int DEF_MAX_HOLD = 4;

  // Widest requester vector the helper function can encode.
  localparam int MAX_N = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // OR-ing the indices of all set bits gives the index directly for a
  // one-hot input and avoids a priority chain.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector.
//   Ports:
//     req      in  N_REQ  request levels
//     last     in  SEL_W  index of the most recently released requester
//     pick     out N_REQ  one-hot winner (zero when no request)
//     pick_idx out SEL_W  encoded winner index
//     any_req  out 1      at least one request is present
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [N_REQ-1:0] pick,
  output logic [SEL_W-1:0] pick_idx,
  output logic             any_req
);

  logic found;

  // Search last+1, last+2, ... wrapping; the last requester itself is
  // visited at the very end, so it has the lowest priority.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!found && req[(int'(last) + off) % N_REQ]) begin
        pick[(int'(last) + off) % N_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign pick_idx = SEL_W'(onehot_to_idx(MAX_N'(pick)));
  assign any_req  = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter and sequencer for a shared N:1 mux channel. Grants one
//   requester at a time, drives the mux select and registers the selected lane
//   into a single valid/ready output stage. A grant lasts until the requester
//   drops its request or MAX_HOLD beats have been accepted; every release is
//   followed by one idle cycle in which re-arbitration takes place.
//   Ports:
//     clk_311         in  1            clock, rising edge
//     rst_n_311       in  1            synchronous reset, active low
//     req_311         in  N_REQ        request levels
//     din_311         in  N_REQ*DATA_W lane i at [i*DATA_W +: DATA_W]
//     gnt_311         out N_REQ        registered one-hot grant
//     sel_311         out SEL_W        registered grant index
//     ack_311         out N_REQ        combinational beat-accept pulse
//     dout_311        out DATA_W       registered output data
//     dout_valid_311  out 1            output stage holds a beat
//     dout_ready_311  in  1            downstream accepts the beat
//     lock_311        in  1            (only with MUX_ARB_LOCK_EN) suppresses
//                                      the MAX_HOLD rotation while high
//   Build option: define MUX_ARB_LOCK_EN to add the lock_311 input.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                    clk_311,
  input  logic                    rst_n_311,
`ifdef MUX_ARB_LOCK_EN
  input  logic                    lock_311,
`endif
  input  logic [N_REQ-1:0]        req_311,
  input  logic [N_REQ*DATA_W-1:0] din_311,
  output logic [N_REQ-1:0]        gnt_311,
  output logic [SEL_W-1:0]        sel_311,
  output logic [N_REQ-1:0]        ack_311,
  output logic [DATA_W-1:0]       dout_311,
  output logic                    dout_valid_311,
  input  logic                    dout_ready_311
);

  // Wide enough to count up to MAX_HOLD on the releasing beat.
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [SEL_W-1:0]  last_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              load_en;
  logic              at_limit;
  logic              release_now;
  logic              lock_active;
  logic [N_REQ-1:0]  pick;
  logic [SEL_W-1:0]  pick_idx;
  logic              any_req;
  logic [DATA_W-1:0] lanes [N_REQ];

`ifdef MUX_ARB_LOCK_EN
  assign lock_active = lock_311;
`else
  assign lock_active = 1'b0;
`endif

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lanes[i] = din_311[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req      (req_311),
    .last     (last_idx),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any_req  (any_req)
  );

  assign at_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Beat acceptance and release decision. Everything is masked while reset
  // is asserted so no ack escapes during the reset cycle.
  always_comb begin
    load_en     = 1'b0;
    release_now = 1'b0;
    ack_311     = '0;
    if (rst_n_311 && (state == ST_GRANT)) begin
      load_en          = req_311[sel_311] && (!dout_valid_311 || dout_ready_311);
      ack_311[sel_311] = load_en;
      release_now      = !req_311[sel_311] || (load_en && at_limit && !lock_active);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (any_req)     state_next = ST_GRANT;
      ST_GRANT: if (release_now) state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_311) begin
    if (!rst_n_311) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant, pointer and hold counter. The select is left alone on release so
  // the mux stays put while the last beat drains.
  always_ff @(posedge clk_311) begin
    if (!rst_n_311) begin
      gnt_311  <= '0;
      sel_311  <= '0;
      last_idx <= SEL_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (any_req) begin
        gnt_311  <= pick;
        sel_311  <= pick_idx;
        hold_cnt <= '0;
      end
    end else begin
      // Under lock the counter parks at MAX_HOLD-1 so that dropping the
      // lock releases the grant on the very next accepted beat.
      if (load_en && !(lock_active && at_limit)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (release_now) begin
        gnt_311  <= '0;
        last_idx <= sel_311;
      end
    end
  end

  // Output stage: independent of the arbiter state so a beat loaded on the
  // releasing cycle still drains normally while the arbiter sits in IDLE.
  always_ff @(posedge clk_311) begin
    if (!rst_n_311) begin
      dout_311       <= '0;
      dout_valid_311 <= 1'b0;
    end else if (load_en) begin
      dout_311       <= lanes[sel_311];
      dout_valid_311 <= 1'b1;
    end else if (dout_valid_311 && dout_ready_311) begin
      dout_valid_311 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Self-checking bench for mux_rr_arbiter (N_REQ=4, DATA_W=8, MAX_HOLD=4).
//   A behavioural model tracks the current owner, beats taken and the
//   round-robin pointer as plain integers and predicts every output each cycle.
//   Define MUX_ARB_LOCK_EN to build and exercise the lock input.
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int MH = 4;
`ifdef MUX_ARB_LOCK_EN
  localparam bit LOCK_BUILT = 1'b1;
`else
  localparam bit LOCK_BUILT = 1'b0;
`endif

  logic            clk_311 = 1'b0;
  logic            rst_n_311;
  logic            lock_311;
  logic [N-1:0]    req_311;
  logic [N*DW-1:0] din_311;
  logic [N-1:0]    gnt_311;
  logic [SW-1:0]   sel_311;
  logic [N-1:0]    ack_311;
  logic [DW-1:0]   dout_311;
  logic            dout_valid_311;
  logic            dout_ready_311;

  logic [DW-1:0]   laneData [N];

  // Reference model state
  int              mOwner;
  int              mLast;
  int              mBeats;
  logic            mValid;
  logic [DW-1:0]   mDout;
  int              mSel;
  logic [N-1:0]    expAck;

  int              assertCount = 0;
  int              failCount   = 0;

  always #5 clk_311 = ~clk_311;

  assign din_311 = {laneData[3], laneData[2], laneData[1], laneData[0]};

  mux_rr_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .SEL_W    (SW),
    .MAX_HOLD (MH)
  ) dut (
    .clk_311        (clk_311),
    .rst_n_311      (rst_n_311),
`ifdef MUX_ARB_LOCK_EN
    .lock_311       (lock_311),
`endif
    .req_311        (req_311),
    .din_311        (din_311),
    .gnt_311        (gnt_311),
    .sel_311        (sel_311),
    .ack_311        (ack_311),
    .dout_311       (dout_311),
    .dout_valid_311 (dout_valid_311),
    .dout_ready_311 (dout_ready_311)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [N-1:0] modelAck(input logic rst, input logic [N-1:0] r,
                                            input logic rdy);
    if (!rst || mOwner < 0) return '0;
    if (r[mOwner] && (!mValid || rdy)) return N'(1 << mOwner);
    return '0;
  endfunction

  // One clock edge of the reference behaviour.
  task automatic modelStep(input logic rst, input logic [N-1:0] r, input logic rdy,
                           input logic lk);
    bit found;
    bit lockOn;
    lockOn = lk && LOCK_BUILT;
    if (!rst) begin
      mOwner = -1; mLast = N - 1; mBeats = 0;
      mValid = 1'b0; mDout = '0; mSel = 0;
      return;
    end
    if (expAck != '0) begin
      mDout  = laneData[mOwner];
      mValid = 1'b1;
    end else if (mValid && rdy) begin
      mValid = 1'b0;
    end
    if (mOwner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && r[(mLast + k) % N]) begin
          mOwner = (mLast + k) % N;
          found  = 1'b1;
        end
      end
      if (found) begin
        mSel   = mOwner;
        mBeats = 0;
      end
    end else if (!r[mOwner]) begin
      mLast  = mOwner;
      mOwner = -1;
    end else if (expAck != '0) begin
      if (!lockOn && (mBeats + 1 >= MH)) begin
        mLast  = mOwner;
        mOwner = -1;
      end else begin
        mBeats = (mBeats + 1 > MH - 1) ? MH - 1 : mBeats + 1;
      end
    end
  endtask

  // Called at a falling edge: drive inputs, check the combinational ack,
  // clock once, then check registered outputs at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] r,
                               input logic rdy, input logic lk);
    rst_n_311      = rst;
    req_311        = r;
    dout_ready_311 = rdy;
    lock_311       = lk;
    #1;
    expAck = modelAck(rst, r, rdy);
    checkOutput("ack", 32'(ack_311), 32'(expAck));
    @(posedge clk_311);
    modelStep(rst, r, rdy, lk);
    @(negedge clk_311);
    checkOutput("gnt", 32'(gnt_311), (mOwner < 0) ? 32'd0 : 32'(1 << mOwner));
    checkOutput("sel", 32'(sel_311), 32'(mSel));
    checkOutput("dout_valid", 32'(dout_valid_311), 32'(mValid));
    checkOutput("dout", 32'(dout_311), 32'(mDout));
    // Requesters advance their data once a beat has been accepted.
    for (int i = 0; i < N; i++) begin
      if (expAck[i]) laneData[i] = laneData[i] + 8'd1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks;
    logic [N-1:0] rr;
    mOwner = -1; mLast = N - 1; mBeats = 0; mValid = 1'b0; mDout = '0; mSel = 0;
    expAck = '0;
    rst_n_311 = 1'b0; req_311 = '0; dout_ready_311 = 1'b1; lock_311 = 1'b0;
    for (int i = 0; i < N; i++) laneData[i] = 8'(16 * (i + 1));
    @(negedge clk_311);

    $display("[TB] reset with all requests raised");
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    checkOutput("first_gnt", 32'(gnt_311), 32'd1);

    $display("[TB] fairness with all requesters active");
    for (int c = 0; c < 22; c++) applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);

    $display("[TB] early drop on requester 2");
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    laneData[2] = 8'hA5;
    acks = 0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0);
      if (expAck[2]) acks++;
    end
    checkOutput("drop_acks", 32'(acks), 32'd2);
    checkOutput("drop_dout", 32'(dout_311), 32'hA6);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0101, 1'b1, 1'b0);
    checkOutput("after_drop_gnt", 32'(gnt_311), 32'd1);
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 4'b0101, 1'b1, 1'b0);

    $display("[TB] backpressure in the middle of a burst");
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, 4'b0010, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
    checkOutput("midrst_valid", 32'(dout_valid_311), 32'd0);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    checkOutput("midrst_gnt", 32'(gnt_311), 32'd1);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);

    if (LOCK_BUILT) begin
      $display("[TB] lock holds the grant past MAX_HOLD");
      applyStimulus(1'b0, 4'b1001, 1'b1, 1'b1);
      for (int c = 0; c < 11; c++) applyStimulus(1'b1, 4'b1001, 1'b1, 1'b1);
      checkOutput("lock_gnt", 32'(gnt_311), 32'd1);
      for (int c = 0; c < 4; c++) applyStimulus(1'b1, 4'b1001, 1'b1, 1'b0);
    end

    $display("[TB] randomized traffic");
    rr = 4'b1010;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 9) < 3) rr = 4'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 59) != 0), rr, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
